up_down_sweep_ctrl: RTL
=======================

Name: up_down_sweep_ctrl

Overview:
Sequencing controller for the 4-bit synchronous up/down counter datapath. Software gives it a lower bound, an upper bound and a sweep count. It then drives the counter as a triangle sweep: count up from lo to hi, down to hi-1 … lo, and repeat. After the programmed number of sweeps it signals done. The block owns the count register and the mode (direction) output, so downstream logic sees the same count/mode pair as the plain counter.

Parameters:
WIDTH, 4, count/bound width
CYCW, 4, sweep-counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  begin a sweep run; sampled only in IDLE
stop  input  1  abort the run; sampled in UP/DOWN
hold  input  1  freeze all state while high, in UP/DOWN
lo  input  WIDTH  lower bound; latched on accepted start
hi  input  WIDTH  upper bound; latched on accepted start
n_sweeps  input  CYCW  number of full up+down sweeps; latched on accepted start
count  output  WIDTH  current count value
mode  output  1  1 = counting up, 0 = counting down
busy  output  1  high in UP and DOWN
done  output  1  one-cycle pulse when the run completes
err  output  1  one-cycle pulse when a start is rejected
sweep_cnt  output  CYCW  completed sweeps in the current or last run

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces:
  - state IDLE
  - count=0, mode=1, busy=0, done=0, err=0, sweep_cnt=0
  - latched lo/hi/n cleared to 0
- States: IDLE, UP, DOWN, DONE.
- mode is 0 only in DOWN; it is 1 in IDLE, UP and DONE.
- IDLE:
  - count holds its value.
  - start with lo<hi and n_sweeps!=0 is accepted. Next edge: latch lo/hi/n, count<=lo, sweep_cnt<=0, state<=UP.
  - start with lo>=hi or n_sweeps==0 is rejected: err=1 for one cycle, stay IDLE, count unchanged.
  - stop and hold are ignored in IDLE.
- UP (hold=0, stop=0):
  - count<hi_l: count<=count+1.
  - count==hi_l: count<=count-1, state<=DOWN. hi appears for exactly one cycle.
- DOWN (hold=0, stop=0):
  - count>lo_l: count<=count-1.
  - count==lo_l: sweep_cnt<=sweep_cnt+1.
    - If sweep_cnt+1==n_l: state<=DONE, count holds lo.
    - Otherwise: count<=lo_l+1, state<=UP.
  - lo appears for exactly one cycle per turnaround.
- DONE:
  - done=1 and busy=0 for this single cycle.
  - Next edge goes to IDLE. count stays at lo; sweep_cnt stays at n.
- Timing: each sweep is 2*(hi-lo) cycles. Take the cycle in which start is sampled as cycle 0. Then count=lo in cycle 1 and done is high in cycle 2*(hi-lo)*n+2.
- hold=1 in UP/DOWN: count, state, sweep_cnt and mode are frozen. busy stays 1.
- stop=1 in UP/DOWN: next edge goes to IDLE. count freezes at its current value, busy<=0, no done pulse. stop has priority over hold.
- start while busy is ignored. lo/hi/n_sweeps changes while busy have no effect.
- No arithmetic wrap-around ever occurs, since lo<hi is guaranteed. Full range lo=0, hi=2^WIDTH-1 is legal.
- Reset asserted mid-run: immediate (asynchronous) return to reset values. The run is not resumed after reset releases.

Test Plan:
- Basic run: lo=2, hi=5, n=2, start pulse in cycle 0. Required count, cycles 1–13: 2,3,4,5,4,3,2,3,4,5,4,3,2. mode=0 on the descending values. done=1 only in cycle 14, then busy=0, sweep_cnt=2.
- Hold: same run with hold=1 for 3 cycles while count=4 (ascending). Required: count stays 4, mode=1, busy=1 for those 3 cycles. The sequence then resumes 5,4,…; done is delayed by exactly 3 cycles (cycle 17).
- Stop: lo=1, hi=6, n=3; assert stop while count=5 descending. Required: next cycle state IDLE, busy=0, count=5, sweep_cnt=0, no done pulse. A new start is accepted afterwards.
- Rejected start: lo=5, hi=5, n=1 → err=1 one cycle, busy stays 0, count unchanged. Then lo=0, hi=3, n=0 → err=1 again.
- Full range: lo=0, hi=15, n=1. Required: count 0..15..0 with no wrap, 15 held for one cycle, done in cycle 32.
- Async reset: drive reset=0 mid-DOWN between clock edges. Required: immediately count=0, mode=1, busy=0, sweep_cnt=0. Remains IDLE after release until a new start.

Source files
------------

// File: rtl/up_down_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl
//
// Drives a WIDTH-bit up/down count as a triangle sweep between a lower bound
// and an upper bound: lo, lo+1 ... hi, hi-1 ... lo, lo+1 ... hi ... lo.
// The bounds and the number of sweeps are latched when a start is accepted.
// After the programmed number of full up+down sweeps it pulses done and goes
// back to idle. The block owns the count register and the direction (mode)
// bit, so downstream logic sees the same count/mode pair as a plain counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   begin a run (looked at only while idle)
//   stop      in   abort a run (looked at only while sweeping, beats hold)
//   hold      in   freeze the sweep while high (only while sweeping)
//   lo, hi    in   sweep bounds, latched on an accepted start
//   n_sweeps  in   number of up+down sweeps, latched on an accepted start
//   count     out  current count value
//   mode      out  1 = counting up, 0 = counting down
//   busy      out  high while sweeping up or down
//   done      out  one-cycle pulse when the run completes
//   err       out  one-cycle pulse when a start is rejected
//   sweep_cnt out  completed sweeps of the current or last run
// -----------------------------------------------------------------------------
module up_down_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int CYCW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYCW-1:0]  n_sweeps,
  output logic [WIDTH-1:0] count,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYCW-1:0]  sweep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CYCW-1:0]  r_n;
  logic [WIDTH-1:0] r_count;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CYCW-1:0]  r_sweep_cnt;

  logic             w_start_ok;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] w_count_dec;
  logic [CYCW-1:0]  w_sweep_inc;
  logic             w_last_sweep;

  // A run needs a non-empty interval and at least one sweep; everything else
  // is rejected up front so the sweep arithmetic can never wrap.
  assign w_start_ok   = (lo < hi) && (n_sweeps != '0);
  assign w_count_inc  = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_count_dec  = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_sweep_inc  = r_sweep_cnt + {{(CYCW-1){1'b0}}, 1'b1};
  assign w_last_sweep = (w_sweep_inc == r_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_n         <= '0;
      r_count     <= '0;
      r_mode      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      // done and err are single-cycle pulses; they are only set on the
      // transitions that produce them.
      r_done <= 1'b0;
      r_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_lo        <= lo;
              r_hi        <= hi;
              r_n         <= n_sweeps;
              r_count     <= lo;
              r_sweep_cnt <= '0;
              r_mode      <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_UP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_UP: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_mode  <= 1'b1;
            r_state <= S_IDLE;
          end else if (!hold) begin
            if (r_count == r_hi) begin
              // Turn around right away so hi is shown for a single cycle.
              r_count <= w_count_dec;
              r_mode  <= 1'b0;
              r_state <= S_DOWN;
            end else begin
              r_count <= w_count_inc;
            end
          end
        end

        S_DOWN: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_mode  <= 1'b1;
            r_state <= S_IDLE;
          end else if (!hold) begin
            if (r_count == r_lo) begin
              r_sweep_cnt <= w_sweep_inc;
              r_mode      <= 1'b1;
              if (w_last_sweep) begin
                // Park on lo and report completion.
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                // lo was already shown in this cycle; the next sweep
                // starts one step above it.
                r_count <= w_count_inc;
                r_state <= S_UP;
              end
            end else begin
              r_count <= w_count_dec;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign count     = r_count;
  assign mode      = r_mode;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign sweep_cnt = r_sweep_cnt;

endmodule
